// File: rtl/sign_conditioning_unit.sv
// sign_conditioning_unit: combinational degree-based sine/cosine lookup plus a
// per-bit debounce-and-lockout filter for the switching-surface sign bits.
module sign_conditioning_unit #(
   parameter int DEBOUNCE_TIME = 5,
   parameter int DELAY         = 500,
   parameter int N             = 2
) (
   input  logic               i_clock,
   input  logic               i_RESET,
   input  logic [N-1:0]       i_signal,
   output logic [N-1:0]       o_signal,
   input  logic signed [31:0] i_theta,
   output logic signed [31:0] o_cos,
   output logic signed [31:0] o_sin
);

   localparam int DW = $clog2(DEBOUNCE_TIME) + 1;
   localparam int LW = $clog2(DELAY) + 1;
   localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_TIME - 1);
   localparam logic [LW-1:0] DELAY_LOAD    = LW'(DELAY);

   // Quarter-wave table: round(1024 * sin(k degrees)) for k = 0..90.
   function automatic logic [10:0] quarter_sine(input logic [6:0] k);
      logic [10:0] q;
      q = 11'd0;
      case (k)
         7'd0:  q = 11'd0;    7'd1:  q = 11'd18;   7'd2:  q = 11'd36;   7'd3:  q = 11'd54;
         7'd4:  q = 11'd71;   7'd5:  q = 11'd89;   7'd6:  q = 11'd107;  7'd7:  q = 11'd125;
         7'd8:  q = 11'd143;  7'd9:  q = 11'd160;  7'd10: q = 11'd178;  7'd11: q = 11'd195;
         7'd12: q = 11'd213;  7'd13: q = 11'd230;  7'd14: q = 11'd248;  7'd15: q = 11'd265;
         7'd16: q = 11'd282;  7'd17: q = 11'd299;  7'd18: q = 11'd316;  7'd19: q = 11'd333;
         7'd20: q = 11'd350;  7'd21: q = 11'd367;  7'd22: q = 11'd384;  7'd23: q = 11'd400;
         7'd24: q = 11'd416;  7'd25: q = 11'd433;  7'd26: q = 11'd449;  7'd27: q = 11'd465;
         7'd28: q = 11'd481;  7'd29: q = 11'd496;  7'd30: q = 11'd512;  7'd31: q = 11'd527;
         7'd32: q = 11'd543;  7'd33: q = 11'd558;  7'd34: q = 11'd573;  7'd35: q = 11'd587;
         7'd36: q = 11'd602;  7'd37: q = 11'd616;  7'd38: q = 11'd630;  7'd39: q = 11'd644;
         7'd40: q = 11'd658;  7'd41: q = 11'd672;  7'd42: q = 11'd685;  7'd43: q = 11'd698;
         7'd44: q = 11'd711;  7'd45: q = 11'd724;  7'd46: q = 11'd737;  7'd47: q = 11'd749;
         7'd48: q = 11'd761;  7'd49: q = 11'd773;  7'd50: q = 11'd784;  7'd51: q = 11'd796;
         7'd52: q = 11'd807;  7'd53: q = 11'd818;  7'd54: q = 11'd828;  7'd55: q = 11'd839;
         7'd56: q = 11'd849;  7'd57: q = 11'd859;  7'd58: q = 11'd868;  7'd59: q = 11'd878;
         7'd60: q = 11'd887;  7'd61: q = 11'd896;  7'd62: q = 11'd904;  7'd63: q = 11'd912;
         7'd64: q = 11'd920;  7'd65: q = 11'd928;  7'd66: q = 11'd935;  7'd67: q = 11'd943;
         7'd68: q = 11'd949;  7'd69: q = 11'd956;  7'd70: q = 11'd962;  7'd71: q = 11'd968;
         7'd72: q = 11'd974;  7'd73: q = 11'd979;  7'd74: q = 11'd984;  7'd75: q = 11'd989;
         7'd76: q = 11'd994;  7'd77: q = 11'd998;  7'd78: q = 11'd1002; 7'd79: q = 11'd1005;
         7'd80: q = 11'd1008; 7'd81: q = 11'd1011; 7'd82: q = 11'd1014; 7'd83: q = 11'd1016;
         7'd84: q = 11'd1018; 7'd85: q = 11'd1020; 7'd86: q = 11'd1022; 7'd87: q = 11'd1023;
         7'd88: q = 11'd1023; 7'd89: q = 11'd1024; 7'd90: q = 11'd1024;
         default: q = 11'd0;
      endcase
      return q;
   endfunction

   logic signed [31:0] theta_rem;
   logic [8:0]         angle;
   logic [6:0]         sin_arg;
   logic [6:0]         cos_arg;
   logic               sin_neg;
   logic               cos_neg;
   logic signed [31:0] sin_ext;
   logic signed [31:0] cos_ext;

   // Reduce the angle; a negative remainder wraps up into 0..359.
   always_comb begin
      theta_rem = i_theta % 32'sd360;
   end

   assign angle = theta_rem[31] ? 9'(theta_rem + 32'sd360) : theta_rem[8:0];

   // Fold the angle into the first quadrant and remember which outputs negate.
   always_comb begin
      sin_arg = angle[6:0];
      cos_arg = 7'(9'd90 - angle);
      sin_neg = 1'b0;
      cos_neg = 1'b0;
      if (angle <= 9'd90) begin
         sin_arg = angle[6:0];
         cos_arg = 7'(9'd90 - angle);
      end else if (angle <= 9'd180) begin
         sin_arg = 7'(9'd180 - angle);
         cos_arg = 7'(angle - 9'd90);
         cos_neg = 1'b1;
      end else if (angle <= 9'd270) begin
         sin_arg = 7'(angle - 9'd180);
         cos_arg = 7'(9'd270 - angle);
         sin_neg = 1'b1;
         cos_neg = 1'b1;
      end else begin
         sin_arg = 7'(9'd360 - angle);
         cos_arg = 7'(angle - 9'd270);
         sin_neg = 1'b1;
      end
   end

   assign sin_ext = {21'd0, quarter_sine(sin_arg)};
   assign cos_ext = {21'd0, quarter_sine(cos_arg)};
   assign o_sin   = sin_neg ? -sin_ext : sin_ext;
   assign o_cos   = cos_neg ? -cos_ext : cos_ext;

   logic [DW-1:0] dcnt [N];
   logic [LW-1:0] lcnt [N];

   // Per-bit filter: count stable differing samples, accept on the last one,
   // then hold the bit in lockout while ignoring its input.
   always_ff @(posedge i_clock or negedge i_RESET) begin
      if (!i_RESET) begin
         o_signal <= '0;
         for (int i = 0; i < N; i++) begin
            dcnt[i] <= '0;
            lcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (lcnt[i] != '0) begin
               lcnt[i] <= lcnt[i] - LW'(1);
               dcnt[i] <= '0;
            end else if (i_signal[i] != o_signal[i]) begin
               if (dcnt[i] == DEBOUNCE_LAST) begin
                  o_signal[i] <= i_signal[i];
                  dcnt[i]     <= '0;
                  lcnt[i]     <= DELAY_LOAD;
               end else begin
                  dcnt[i] <= dcnt[i] + DW'(1);
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sign_conditioning_unit.sv
// tb_sign_conditioning_unit: directed vectors for the trig lookup and the
// debounce/lockout filter, checked against a window-based behavioural model.
module tb_sign_conditioning_unit;

   localparam int DT  = 5;
   localparam int DLY = 500;
   localparam int NB  = 2;

   logic               clock   = 1'b0;
   logic               reset_n = 1'b0;
   logic [NB-1:0]      sig_in  = '0;
   logic [NB-1:0]      sig_out;
   logic signed [31:0] theta   = '0;
   logic signed [31:0] cos_out;
   logic signed [31:0] sin_out;

   int checks   = 0;
   int failures = 0;

   sign_conditioning_unit #(
      .DEBOUNCE_TIME(DT),
      .DELAY(DLY),
      .N(NB)
   ) dut (
      .i_clock(clock),
      .i_RESET(reset_n),
      .i_signal(sig_in),
      .o_signal(sig_out),
      .i_theta(theta),
      .o_cos(cos_out),
      .o_sin(sin_out)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Behavioural filter model: a bit flips at an edge when the last DT samples
   // (all taken at or after the bit's unlock edge) all disagree with it.
   logic [NB-1:0] samples[$];
   int            unlock_at [NB];
   logic [NB-1:0] model_out = '0;
   int            e_now;
   bit            settled;

   initial forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         samples.delete();
         model_out = '0;
         for (int i = 0; i < NB; i++) unlock_at[i] = 0;
      end else begin
         samples.push_back(sig_in);
         e_now = samples.size() - 1;
         for (int i = 0; i < NB; i++) begin
            settled = (e_now - DT + 1) >= unlock_at[i];
            if (settled) begin
               for (int j = e_now - DT + 1; j <= e_now; j++) begin
                  if (samples[j][i] == model_out[i]) settled = 1'b0;
               end
            end
            if (settled) begin
               model_out[i] = samples[e_now][i];
               unlock_at[i] = e_now + DLY + 1;
            end
         end
      end
   end

   // Compare the registered output against the model just after every edge.
   initial forever begin
      @(posedge clock);
      #1;
      checks++;
      if (sig_out !== model_out) begin
         failures++;
         $display("[TB] FAIL cycle_model t=%0t: o_signal=%b expected=%b", $time, sig_out, model_out);
      end
   end

   task automatic applyStimulus(input logic [NB-1:0] v);
      sig_in = v;
   endtask

   task automatic checkOutput(input string name, input logic [NB-1:0] expected);
      checks++;
      if (sig_out !== expected) begin
         failures++;
         $display("[TB] FAIL %s: o_signal=%b expected=%b", name, sig_out, expected);
      end
   endtask

   task automatic checkTrig(input string name, input int t, input int exp_cos, input int exp_sin);
      theta = t;
      #1;
      checks++;
      if (cos_out !== exp_cos) begin
         failures++;
         $display("[TB] FAIL %s_cos theta=%0d: o_cos=%0d expected=%0d", name, t, cos_out, exp_cos);
      end
      checks++;
      if (sin_out !== exp_sin) begin
         failures++;
         $display("[TB] FAIL %s_sin theta=%0d: o_sin=%0d expected=%0d", name, t, sin_out, exp_sin);
      end
   endtask

   function automatic void trigModel(input int t, output int c, output int s);
      int  r;
      real rad;
      r = t % 360;
      if (r < 0) r += 360;
      rad = real'(r) * 3.141592653589793 / 180.0;
      c = $rtoi($floor($cos(rad) * 1024.0 + 0.5));
      s = $rtoi($floor($sin(rad) * 1024.0 + 0.5));
   endfunction

   int mc;
   int ms;

   initial begin
      applyStimulus(2'b00);
      reset_n = 1'b0;
      #1;
      checkOutput("reset_state", 2'b00);

      // Trig path: hand-computed points, then a model sweep.
      checkTrig("th0", 0, 1024, 0);
      checkTrig("th30", 30, 887, 512);
      checkTrig("th90", 90, 0, 1024);
      checkTrig("th225", 225, -724, -724);
      checkTrig("thm90", -90, 0, -1024);
      checkTrig("th450", 450, 0, 1024);
      checkTrig("thm720", -720, 1024, 0);
      for (int t = -800; t <= 800; t++) begin
         trigModel(t, mc, ms);
         checkTrig("sweep", t, mc, ms);
      end
      trigModel(32'sh7fffffff, mc, ms);
      checkTrig("max_int", 32'sh7fffffff, mc, ms);
      trigModel(32'sh80000000, mc, ms);
      checkTrig("min_int", 32'sh80000000, mc, ms);

      // Clean step: 00 through edge 9, 01 first sampled at edge 10.
      @(negedge clock);
      reset_n = 1'b1;
      repeat (9) @(negedge clock);
      applyStimulus(2'b01);
      repeat (4) @(posedge clock);
      #1 checkOutput("step_edge13", 2'b00);
      @(posedge clock);
      #1 checkOutput("step_edge14", 2'b01);

      // Bit1 changes while bit0 is locked out.
      repeat (6) @(negedge clock);
      applyStimulus(2'b11);
      repeat (4) @(posedge clock);
      #1 checkOutput("bit1_not_yet", 2'b01);
      @(posedge clock);
      #1 checkOutput("bit1_rise", 2'b11);

      // Asynchronous reset in the middle of lockout.
      repeat (50) @(negedge clock);
      #2 reset_n = 1'b0;
      #1 checkOutput("async_reset", 2'b00);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(posedge clock);
      #1 checkOutput("post_reset_edge4", 2'b00);
      @(posedge clock);
      #1 checkOutput("post_reset_edge5", 2'b11);

      // Fresh start for the glitch and lockout checks.
      @(negedge clock);
      reset_n = 1'b0;
      applyStimulus(2'b00);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      applyStimulus(2'b01);
      repeat (4) @(negedge clock);
      applyStimulus(2'b00);
      repeat (10) @(posedge clock);
      #1 checkOutput("glitch4", 2'b00);

      // Five-sample pulse is accepted at edge E; input drops at E+1.
      @(negedge clock);
      applyStimulus(2'b01);
      repeat (4) @(posedge clock);
      #1 checkOutput("pulse5_edge4", 2'b00);
      @(posedge clock);
      #1 checkOutput("pulse5_accept", 2'b01);
      @(negedge clock);
      applyStimulus(2'b00);

      // Bit1 rises during bit0's lockout; bit0 timing must be unaffected.
      repeat (20) @(negedge clock);
      applyStimulus(2'b10);
      repeat (4) @(posedge clock);
      #1 checkOutput("indep_bit1_wait", 2'b01);
      @(posedge clock);
      #1 checkOutput("indep_bit1_rise", 2'b11);
      repeat (479) @(posedge clock);
      #1 checkOutput("lockout_hold", 2'b11);
      @(posedge clock);
      #1 checkOutput("lockout_release", 2'b10);

      repeat (10) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sign_conditioning_unit.md
# sign_conditioning_unit

Front-end conditioning block for the hybrid resonant-converter controller. It combines a combinational degree-based sine/cosine generator (function `trigonometry_deg`) with a per-bit debounce-and-lockout filter (function `regularization`). The controller uses these to get the switching-surface coefficients and to get clean sign bits of the surfaces before the jump logic. Both functions sit in one block but are otherwise independent.

## Interface
- DEBOUNCE_TIME, 5: consecutive stable clock cycles needed to accept a bit change (≥1).
- DELAY, 500: lockout cycles after an accepted change, during which that bit ignores its input (≥0).
- N, 2: width of the filtered signal vector.
- i_clock  in  1  system clock; all filter state updates on its rising edge.
- i_RESET  in  1  reset, asynchronous, active-low.
- i_signal  in  N  raw sign bits to regularize.
- o_signal  out  N  regularized bits (registered).
- i_theta  in  32 signed  angle in integer degrees, any value.
- o_cos  out  32 signed  cos(i_theta)·1024, combinational.
- o_sin  out  32 signed  sin(i_theta)·1024, combinational.

## Operation
- Trig path (purely combinational, no clock or reset dependence):
  - Compute r = i_theta mod 360, mapped to 0..359. Negative inputs wrap: for a remainder r < 0, add 360.
  - Use a quarter-wave table T[k] = round(1024·sin(k°)) for k = 0..90. Key entries: T[0]=0, T[30]=512, T[45]=724, T[60]=887, T[90]=1024.
  - For 0 ≤ r ≤ 90: sin = T[r], cos = T[90−r].
  - For 90 < r ≤ 180: sin = T[180−r], cos = −T[r−90].
  - For 180 < r ≤ 270: sin = −T[r−180], cos = −T[270−r].
  - For 270 < r < 360: sin = −T[360−r], cos = T[r−270].
  - Outputs are sign-extended to 32 bits. The magnitude is always ≤ 1024, so a product with a 21-bit operand fits in 32 bits.
- Filter path, with independent logic per bit i:
  - State is o_signal[i], a debounce counter dcnt[i] and a lockout counter lcnt[i]. Counter widths are $clog2 of the parameter plus 1.
  - While lcnt[i] > 0: lcnt[i] decrements each cycle, dcnt[i] is held at 0, and the input is ignored.
  - While lcnt[i] = 0:
    - If i_signal[i] ≠ o_signal[i], dcnt[i] increments.
    - If i_signal[i] = o_signal[i], dcnt[i] clears to 0. A glitch therefore restarts the count.
  - When the increment would make dcnt[i] reach DEBOUNCE_TIME, on that same edge: o_signal[i] takes i_signal[i], dcnt[i] is set to 0, and lcnt[i] is loaded with DELAY.
  - With DELAY = 0 there is no lockout and the next change is debounced immediately.
- Reset (asynchronous, active-low): o_signal, all dcnt and all lcnt clear to 0 immediately.
  - After release, the filter behaves as if the output had just been 0 with no lockout pending.
  - A reset mid-count or mid-lockout aborts it.

## Timing
- Trig outputs have zero latency and track i_theta within the same cycle.
- Filter latency:
  - An input that differs from the output and is first sampled at edge k changes o_signal at edge k+DEBOUNCE_TIME−1, provided it stays stable for all DEBOUNCE_TIME samples and no lockout is active.
  - With defaults, the output changes at the 5th sampling edge.
- Pulses shorter than DEBOUNCE_TIME cycles never reach the output.
- After a change at edge m, the input is next examined at edge m+DELAY+1. The minimum spacing between two changes of the same bit is DELAY+DEBOUNCE_TIME cycles.
- A change requested during lockout is not lost if the input stays different: debounce starts when lockout ends.
- Simultaneous changes on several bits are handled independently, so bits may update on the same edge.

## Test plan
- Trig sweep:
  - i_theta = 0 → cos=1024, sin=0.
  - 30 → cos=887, sin=512.
  - 90 → cos=0, sin=1024.
  - 225 → cos=−724, sin=−724.
  - −90 → cos=0, sin=−1024.
  - 450 → cos=0, sin=1024.
  - −720 → cos=1024, sin=0.
- Clean step (defaults): hold i_signal=2'b00 after reset, step to 2'b01 at edge 10 → o_signal=2'b01 from edge 14 on, and bit1 stays 0.
- Glitch rejection: pulse bit0 high for 4 cycles → o_signal stays 2'b00. A 5-cycle pulse → bit0 goes to 1.
- Lockout: after bit0 rises at edge E, drop the input at E+1 and hold it low → bit0 falls at edge E+500+5, and not earlier.
- Reset mid-operation: assert i_RESET low during a lockout with o_signal=2'b11 → o_signal=2'b00 asynchronously. After release, with input held at 2'b11, o_signal=2'b11 5 edges later.
- Independent bits: toggle bit1 only while bit0 is in lockout → bit1 updates after 5 edges, and bit0's lockout timing is unchanged.
